charge_path_sequencer: RTL

Consumes the registered `charge_enable` decision from the moisture-detection stage and sequences the physical charge path. It drives precharge, main contactor close and a soft-start/soft-stop PWM duty ramp, and supervises contactor feedback and overcurrent. It sits between the BMS safety logic and the charger power stage. Any loss of `charge_enable` produces a controlled ramp-down and open. Faults latch until explicitly cleared.

---
 rtl/charge_path_sequencer_if.sv | 24 ++
 rtl/charge_path_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/charge_path_sequencer_if.sv
// Handshake bundle between BMS safety logic and the charge path sequencer.
interface charge_path_sequencer_if;
  logic       charge_enable;
  logic       contactor_ack;
  logic       overcurrent;
  logic       fault_clear;
  logic       precharge_en;
  logic       contactor_close;
  logic [7:0] duty;
  logic       charging;
  logic       fault;

  // Supervisory side: issues permission and feedback, observes drives.
  modport master (
    output charge_enable, contactor_ack, overcurrent, fault_clear,
    input  precharge_en, contactor_close, duty, charging, fault
  );

  // Sequencer side.
  modport slave (
    input  charge_enable, contactor_ack, overcurrent, fault_clear,
    output precharge_en, contactor_close, duty, charging, fault
  );
endinterface

// File: rtl/charge_path_sequencer.sv
// Sequences precharge, contactor close and a duty ramp; supervises ack and overcurrent.
module charge_path_sequencer #(
  parameter int unsigned PRECHARGE_CYCLES = 16,
  parameter int unsigned ACK_TIMEOUT      = 64,
  parameter int unsigned RAMP_STEP        = 16,
  parameter int unsigned RAMP_DIV         = 4,
  parameter int unsigned DUTY_MAX         = 240
) (
  input logic                    clk,
  input logic                    reset_n,
  charge_path_sequencer_if.slave bus
);

  localparam int unsigned DUTY_W  = 8;
  localparam int unsigned SUM_W   = DUTY_W + 1;
  localparam int unsigned CNT_MAX = (PRECHARGE_CYCLES > ACK_TIMEOUT) ? PRECHARGE_CYCLES : ACK_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned DIV_W   = $clog2(RAMP_DIV + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRECHARGE = 3'd1,
    CLOSE     = 3'd2,
    RAMP_UP   = 3'd3,
    CHARGE    = 3'd4,
    RAMP_DN   = 3'd5,
    OPEN      = 3'd6,
    FAULT     = 3'd7
  } state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [DIV_W-1:0]    div, div_n;
  logic [DUTY_W-1:0]   duty_q, duty_n;
  logic [SUM_W-1:0]    sum_up;
  logic                tick;
  logic                precharge_q, close_q, charging_q, fault_q;
  logic                precharge_n, close_n, charging_n, fault_n;

  // Next state, counters and duty; outputs decoded from the next state so they register with it.
  always_comb begin
    state_n     = state;
    cnt_n       = '0;
    div_n       = '0;
    duty_n      = duty_q;
    precharge_n = 1'b0;
    close_n     = 1'b0;
    charging_n  = 1'b0;
    fault_n     = 1'b0;
    tick        = (div == DIV_W'(RAMP_DIV - 1));
    sum_up      = {1'b0, duty_q} + SUM_W'(RAMP_STEP);

    unique case (state)
      IDLE: begin
        if (bus.charge_enable) state_n = PRECHARGE;
      end
      PRECHARGE: begin
        cnt_n = cnt + CNT_W'(1);
        if (!bus.charge_enable)                          state_n = OPEN;
        else if (cnt == CNT_W'(PRECHARGE_CYCLES - 1))    state_n = CLOSE;
      end
      CLOSE: begin
        cnt_n = cnt + CNT_W'(1);
        if (cnt == CNT_W'(ACK_TIMEOUT - 1))  state_n = FAULT;
        else if (!bus.charge_enable)         state_n = OPEN;
        else if (bus.contactor_ack)          state_n = RAMP_UP;
      end
      RAMP_UP: begin
        if (!bus.charge_enable) begin
          state_n = RAMP_DN;
        end else if (tick) begin
          duty_n = (sum_up >= SUM_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : sum_up[DUTY_W-1:0];
          if (duty_n == DUTY_W'(DUTY_MAX)) state_n = CHARGE;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      CHARGE: begin
        if (!bus.contactor_ack)      state_n = FAULT;
        else if (!bus.charge_enable) state_n = RAMP_DN;
      end
      RAMP_DN: begin
        // Once started the ramp-down always completes; re-entry is only via IDLE.
        if (tick) begin
          duty_n = (duty_q > DUTY_W'(RAMP_STEP)) ? duty_q - DUTY_W'(RAMP_STEP) : '0;
          if (duty_n == '0) state_n = OPEN;
        end else begin
          div_n = div + DIV_W'(1);
        end
      end
      OPEN: begin
        cnt_n = cnt + CNT_W'(1);
        if (!bus.contactor_ack)                    state_n = IDLE;
        else if (cnt == CNT_W'(ACK_TIMEOUT - 1))   state_n = FAULT;
      end
      FAULT: begin
        if (bus.fault_clear && !bus.charge_enable && !bus.contactor_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (bus.overcurrent && (state != IDLE) && (state != FAULT)) state_n = FAULT;

    if (state_n != state) begin
      cnt_n = '0;
      div_n = '0;
    end

    unique case (state_n)
      PRECHARGE: precharge_n = 1'b1;
      CLOSE: begin
        precharge_n = 1'b1;
        close_n     = 1'b1;
      end
      RAMP_UP, RAMP_DN: close_n = 1'b1;
      CHARGE: begin
        close_n    = 1'b1;
        charging_n = 1'b1;
        duty_n     = DUTY_W'(DUTY_MAX);
      end
      FAULT: fault_n = 1'b1;
      default: ;
    endcase

    if ((state_n != RAMP_UP) && (state_n != RAMP_DN) && (state_n != CHARGE)) duty_n = '0;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      div         <= '0;
      duty_q      <= '0;
      precharge_q <= 1'b0;
      close_q     <= 1'b0;
      charging_q  <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      div         <= div_n;
      duty_q      <= duty_n;
      precharge_q <= precharge_n;
      close_q     <= close_n;
      charging_q  <= charging_n;
      fault_q     <= fault_n;
    end
  end

  assign bus.precharge_en    = precharge_q;
  assign bus.contactor_close = close_q;
  assign bus.duty            = duty_q;
  assign bus.charging        = charging_q;
  assign bus.fault           = fault_q;

endmodule
